// File: rtl/dram_arb_pkg.sv
// dram_arb_pkg
//   Shared definitions for the N-port DRAM arbiter slice:
//     - arb_state_t : arbiter FSM encoding (IDLE, BUSY_RD, BUSY_WR, DONE)
//     - MAX_PORTS   : largest supported client count
//     - port_onehot : index -> one-hot port mask (MAX_PORTS wide, callers truncate)
//   Optional build macro used by the arbiter: DRAM_ARB_PORT0_PRIO_EN.
package dram_arb_pkg;

    localparam int MAX_PORTS = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_RD = 2'd1,
        ST_BUSY_WR = 2'd2,
        ST_DONE    = 2'd3
    } arb_state_t;

    // Out-of-range indices yield an all-zero mask rather than wrapping.
    function automatic logic [MAX_PORTS-1:0] port_onehot(input int unsigned idx);
        port_onehot = '0;
        if (idx < MAX_PORTS) begin
            port_onehot = MAX_PORTS'(1) << idx;
        end
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
//   Combinational round-robin selector: finds the first set bit of `pending`
//   at or after `ptr`, wrapping from NUM_PORTS-1 back to 0.
// Ports:
//   pending  in   NUM_PORTS  candidate ports
//   ptr      in   PTR_W      search start position (0..NUM_PORTS-1)
//   found    out  1          at least one pending port
//   idx      out  PTR_W      selected port (0 when nothing is pending)
module rr_pick
    import dram_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PTR_W     = 3
) (
    input  logic [NUM_PORTS-1:0] pending,
    input  logic [PTR_W-1:0]     ptr,
    output logic                 found,
    output logic [PTR_W-1:0]     idx
);

    always_comb begin
        int unsigned          cand;
        logic [NUM_PORTS-1:0] cand_oh;
        found   = 1'b0;
        idx     = '0;
        cand    = 0;
        cand_oh = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            cand    = (32'(ptr) + i) % NUM_PORTS;
            cand_oh = NUM_PORTS'(port_onehot(cand));
            if (!found && (|(pending & cand_oh))) begin
                found = 1'b1;
                idx   = PTR_W'(cand);
            end
        end
    end

endmodule

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter
//   Multiplexes NUM_PORTS client masters onto the single sdram_controller3
//   request interface. Round-robin grant, one transaction outstanding, and the
//   completion pulse is routed back to the granted port only.
//
// Handshake: clients hold req_read/req_write as levels together with a stable
//   addr/wdata slice until their rdata_valid/write_complete bit pulses for one
//   cycle; the request must be dropped the cycle after the pulse. Towards the
//   controller, dram_req_* is a level held with stable dram_addr/dram_data_in
//   until the matching done pulse (dram_data_out_valid / dram_write_complete).
//
// Build option: DRAM_ARB_PORT0_PRIO_EN -- a pending port 0 request wins in IDLE
//   regardless of the round-robin pointer; the pointer then does not advance.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   req_read/req_write   per-port request levels (write wins when both set)
//   addr, wdata          per-port packed address / write data
//   rdata                shared read data
//   rdata_valid          one-cycle pulse to the granted reader
//   write_complete       one-cycle pulse to the granted writer
//   dram_*               controller request side
//   dbg_state            current FSM state
module dram_port_arbiter
    import dram_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 32,
    parameter int PTR_W      = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            req_read,
    input  logic [NUM_PORTS-1:0]            req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0]           rdata,
    output logic [NUM_PORTS-1:0]            rdata_valid,
    output logic [NUM_PORTS-1:0]            write_complete,
    output logic [ADDR_WIDTH-1:0]           dram_addr,
    output logic [DATA_WIDTH-1:0]           dram_data_in,
    output logic                            dram_req_read,
    output logic                            dram_req_write,
    input  logic [DATA_WIDTH-1:0]           dram_data_out,
    input  logic                            dram_data_out_valid,
    input  logic                            dram_write_complete,
    output arb_state_t                      dbg_state
);

    arb_state_t           state;
    arb_state_t           state_next;
    logic [PTR_W-1:0]     ptr;
    logic [PTR_W-1:0]     ptr_next;
    logic [PTR_W-1:0]     grant;
    logic [NUM_PORTS-1:0] grant_oh;
    logic [NUM_PORTS-1:0] done_mask;
    logic [NUM_PORTS-1:0] pending;
    logic                 rr_found;
    logic [PTR_W-1:0]     rr_idx;
    logic                 pick_found;
    logic [PTR_W-1:0]     pick_idx;
    logic [NUM_PORTS-1:0] pick_oh;
    logic                 pick_is_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // The port just served is masked for one cycle so a client that has not
    // yet dropped its request is not immediately re-granted.
    assign pending = (req_read | req_write) & ~done_mask;

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PTR_W)
    ) u_rr_pick (
        .pending (pending),
        .ptr     (ptr),
        .found   (rr_found),
        .idx     (rr_idx)
    );

`ifdef DRAM_ARB_PORT0_PRIO_EN
    logic prio_hit;
    logic rr_grant;   // current grant came from the round-robin path

    assign prio_hit   = pending[0];
    assign pick_found = rr_found | prio_hit;
    assign pick_idx   = prio_hit ? '0 : rr_idx;
`else
    assign pick_found = rr_found;
    assign pick_idx   = rr_idx;
`endif

    assign pick_oh       = NUM_PORTS'(port_onehot(32'(pick_idx)));
    assign grant_oh      = NUM_PORTS'(port_onehot(32'(grant)));
    assign pick_is_write = |(req_write & pick_oh);
    assign ptr_next      = (grant == PTR_W'(NUM_PORTS - 1)) ? '0 : grant + PTR_W'(1);
    assign dbg_state     = state;

    // One-hot mux of the selected port's address/data slice.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (pick_oh[p]) begin
                sel_addr  = addr[p*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = wdata[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state logic; mismatched or unsolicited done pulses never move the FSM.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    state_next = pick_is_write ? ST_BUSY_WR : ST_BUSY_RD;
                end
            end
            ST_BUSY_RD: begin
                if (dram_data_out_valid) begin
                    state_next = ST_DONE;
                end
            end
            ST_BUSY_WR: begin
                if (dram_write_complete) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Registered datapath: the controller sees the request one cycle after
    // the grant decision, and clients see completion one cycle after the
    // controller's done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr            <= '0;
            grant          <= '0;
            done_mask      <= '0;
            rdata          <= '0;
            rdata_valid    <= '0;
            write_complete <= '0;
            dram_addr      <= '0;
            dram_data_in   <= '0;
            dram_req_read  <= 1'b0;
            dram_req_write <= 1'b0;
`ifdef DRAM_ARB_PORT0_PRIO_EN
            rr_grant       <= 1'b0;
`endif
        end else begin
            rdata_valid    <= '0;
            write_complete <= '0;
            done_mask      <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant          <= pick_idx;
                        dram_addr      <= sel_addr;
                        dram_data_in   <= sel_wdata;
                        dram_req_write <= pick_is_write;
                        dram_req_read  <= ~pick_is_write;
`ifdef DRAM_ARB_PORT0_PRIO_EN
                        rr_grant       <= ~prio_hit;
`endif
                    end
                end
                ST_BUSY_RD: begin
                    if (dram_data_out_valid) begin
                        rdata         <= dram_data_out;
                        rdata_valid   <= grant_oh;
                        dram_req_read <= 1'b0;
                        done_mask     <= grant_oh;
                    end
                end
                ST_BUSY_WR: begin
                    if (dram_write_complete) begin
                        write_complete <= grant_oh;
                        dram_req_write <= 1'b0;
                        done_mask      <= grant_oh;
                    end
                end
                ST_DONE: begin
`ifdef DRAM_ARB_PORT0_PRIO_EN
                    if (rr_grant) begin
                        ptr <= ptr_next;
                    end
`else
                    ptr <= ptr_next;
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb_dram_port_arbiter
//   Directed bench for dram_port_arbiter (4 ports, 24-bit address, 32-bit data).
//   A behavioural controller answers requests after a programmable latency;
//   expected controller requests and client completions are queued by the
//   stimulus and checked by an independent monitor.
module tb_dram_port_arbiter;
  import dram_arb_pkg::*;

  localparam int NP = 4;
  localparam int AW = 24;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [NP-1:0]    req_read;
  logic [NP-1:0]    req_write;
  logic [NP*AW-1:0] addr;
  logic [NP*DW-1:0] wdata;
  logic [DW-1:0]    rdata;
  logic [NP-1:0]    rdata_valid;
  logic [NP-1:0]    write_complete;
  logic [AW-1:0]    dram_addr;
  logic [DW-1:0]    dram_data_in;
  logic             dram_req_read;
  logic             dram_req_write;
  logic [DW-1:0]    dram_data_out;
  logic             dram_data_out_valid;
  logic             dram_write_complete;
  arb_state_t       dbg_state;

  dram_port_arbiter #(
    .NUM_PORTS  (NP),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .PTR_W      (3)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_read            (req_read),
    .req_write           (req_write),
    .addr                (addr),
    .wdata               (wdata),
    .rdata               (rdata),
    .rdata_valid         (rdata_valid),
    .write_complete      (write_complete),
    .dram_addr           (dram_addr),
    .dram_data_in        (dram_data_in),
    .dram_req_read       (dram_req_read),
    .dram_req_write      (dram_req_write),
    .dram_data_out       (dram_data_out),
    .dram_data_out_valid (dram_data_out_valid),
    .dram_write_complete (dram_write_complete),
    .dbg_state           (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  int pulse_cnt = 0;
  logic [56:0] iss_q[$];   // {is_write, addr[23:0], wdata[31:0]}
  logic [36:0] exp_q[$];   // {is_write, port_oh[3:0], rdata[31:0]}

  // controller model controls (written by stimulus only)
  int dram_lat = 3;
  logic dram_en = 1'b1;
  int inj_wc_req = 0;
  int inj_rv_req = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dram_word(input logic [23:0] a);
    return (a == 24'h000123) ? 32'hDEADBEEF : {8'hA5, a};
  endfunction

  // ---------------- controller model ----------------
  initial begin
    int cnt;
    int wc_done;
    int rv_done;
    cnt = 0;
    wc_done = 0;
    rv_done = 0;
    dram_data_out = '0;
    dram_data_out_valid = 1'b0;
    dram_write_complete = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      dram_data_out_valid = 1'b0;
      dram_write_complete = 1'b0;
      if (inj_wc_req != wc_done) begin
        dram_write_complete = 1'b1;
        wc_done++;
      end else if (inj_rv_req != rv_done) begin
        dram_data_out = 32'hBAD0BAD0;
        dram_data_out_valid = 1'b1;
        rv_done++;
      end else if (dram_en && (dram_req_read || dram_req_write)) begin
        cnt++;
        if (cnt >= dram_lat) begin
          cnt = 0;
          if (dram_req_write) begin
            dram_write_complete = 1'b1;
          end else begin
            dram_data_out = dram_word(dram_addr);
            dram_data_out_valid = 1'b1;
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic prev_req;
    logic [56:0] ie;
    logic [36:0] re;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if ((|rdata_valid) || (|write_complete)) begin
          pulse_cnt++;
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", 64'({rdata_valid, write_complete}), 64'(0));
          end else begin
            re = exp_q.pop_front();
            check("resp_kind", 64'(|write_complete), 64'(re[36]));
            check("resp_port", 64'(re[36] ? write_complete : rdata_valid), 64'(re[35:32]));
            if (!re[36]) check("resp_rdata", 64'(rdata), 64'(re[31:0]));
          end
        end
        if ((dram_req_read || dram_req_write) && !prev_req) begin
          check("req_exclusive", 64'(dram_req_read & dram_req_write), 64'(0));
          if (iss_q.size() == 0) begin
            check("unexpected_issue", 64'(dram_addr), 64'(0));
          end else begin
            ie = iss_q.pop_front();
            check("iss_kind", 64'(dram_req_write), 64'(ie[56]));
            check("iss_addr", 64'(dram_addr), 64'(ie[55:32]));
            if (ie[56]) check("iss_wdata", 64'(dram_data_in), 64'(ie[31:0]));
          end
        end
      end
      prev_req = dram_req_read | dram_req_write;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_rd(input logic [3:0] poh, input logic [23:0] a, input logic [31:0] d);
    iss_q.push_back({1'b0, a, 32'h0});
    exp_q.push_back({1'b0, poh, d});
  endtask

  task automatic push_wr(input logic [3:0] poh, input logic [23:0] a, input logic [31:0] d);
    iss_q.push_back({1'b1, a, d});
    exp_q.push_back({1'b1, poh, 32'h0});
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_read = '0;
    req_write = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Waits for n client completions, dropping each served request.
  task automatic wait_pulses(input int n);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 500) begin
      @(negedge clk);
      cyc++;
      for (int p = 0; p < NP; p++) begin
        if (rdata_valid[p]) begin
          req_read[p] = 1'b0;
          got++;
        end
        if (write_complete[p]) begin
          req_write[p] = 1'b0;
          got++;
        end
      end
    end
    check("pulse_count", 64'(got), 64'(n));
  endtask

  task automatic wait_for_req();
    int cyc;
    logic seen;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 50) begin
      @(negedge clk);
      cyc++;
      seen = dram_req_read | dram_req_write;
    end
    check("req_timeout", 64'(seen), 64'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pc;
    rst = 1'b1;
    req_read = '0;
    req_write = '0;
    addr = '0;
    wdata = '0;
    for (int p = 0; p < NP; p++) wdata[p*DW +: DW] = 32'h11111111 * (p + 1);

    // reset state
    repeat (2) @(negedge clk);
    check("rst_rdata_valid", 64'(rdata_valid), 64'(0));
    check("rst_write_complete", 64'(write_complete), 64'(0));
    check("rst_dram_req_read", 64'(dram_req_read), 64'(0));
    check("rst_dram_req_write", 64'(dram_req_write), 64'(0));
    check("rst_dram_addr", 64'(dram_addr), 64'(0));
    check("rst_rdata", 64'(rdata), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // single read on port 2
    addr[2*AW +: AW] = 24'h000123;
    push_rd(4'b0100, 24'h000123, 32'hDEADBEEF);
    req_read[2] = 1'b1;
    @(posedge clk);
    #1;
    check("t1_req_latency", 64'(dram_req_read), 64'(1));
    check("t1_dram_addr", 64'(dram_addr), 64'h000123);
    check("t1_state", 64'(dbg_state), 64'(ST_BUSY_RD));
    wait_pulses(1);
    @(negedge clk);
    check("t1_valid_one_cycle", 64'(rdata_valid), 64'(0));

    // all four ports read from reset; port 0 re-requests after its grant
    do_reset();
    for (int p = 0; p < NP; p++) addr[p*AW +: AW] = 24'h000100 + 24'(p);
    push_rd(4'b0001, 24'h000100, 32'hA5000100);
    push_rd(4'b0010, 24'h000101, 32'hA5000101);
    push_rd(4'b0100, 24'h000102, 32'hA5000102);
    push_rd(4'b1000, 24'h000103, 32'hA5000103);
    req_read = 4'b1111;
    wait_pulses(1);
    addr[0 +: AW] = 24'h000200;
    push_rd(4'b0001, 24'h000200, 32'hA5000200);
    req_read[0] = 1'b1;
    wait_pulses(4);

    // port 1 read+write together: write first
    addr[1*AW +: AW] = 24'h000040;
    wdata[1*DW +: DW] = 32'h5A5A5A5A;
    push_wr(4'b0010, 24'h000040, 32'h5A5A5A5A);
    push_rd(4'b0010, 24'h000040, 32'hA5000040);
    req_read[1] = 1'b1;
    req_write[1] = 1'b1;
    wait_pulses(2);

    // reset during BUSY_RD, late controller valid ignored
    dram_en = 1'b0;
    addr[3*AW +: AW] = 24'h000055;
    iss_q.push_back({1'b0, 24'h000055, 32'h0});
    req_read[3] = 1'b1;
    wait_for_req();
    check("t4_busy", 64'(dbg_state), 64'(ST_BUSY_RD));
    pc = pulse_cnt;
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_read = '0;
    @(negedge clk);
    check("t4_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("t4_rst_req", 64'(dram_req_read), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    inj_rv_req++;
    repeat (4) @(negedge clk);
    check("t4_no_pulse", 64'(pulse_cnt), 64'(pc));
    check("t4_state_idle", 64'(dbg_state), 64'(ST_IDLE));
    check("t4_req_low", 64'(dram_req_read), 64'(0));
    dram_en = 1'b1;

    // ports 0 and 3 pending with pointer at 1
    do_reset();
    addr[0 +: AW] = 24'h000010;
    push_rd(4'b0001, 24'h000010, 32'hA5000010);
    req_read[0] = 1'b1;
    wait_pulses(1);
    addr[0 +: AW] = 24'h000300;
    addr[3*AW +: AW] = 24'h000303;
`ifdef DRAM_ARB_PORT0_PRIO_EN
    push_rd(4'b0001, 24'h000300, 32'hA5000300);
    push_rd(4'b1000, 24'h000303, 32'hA5000303);
`else
    push_rd(4'b1000, 24'h000303, 32'hA5000303);
    push_rd(4'b0001, 24'h000300, 32'hA5000300);
`endif
    req_read = 4'b1001;
    wait_pulses(2);

    // stray controller write-complete while idle
    repeat (2) @(negedge clk);
    pc = pulse_cnt;
    inj_wc_req++;
    repeat (3) @(negedge clk);
    check("t6_no_pulse", 64'(pulse_cnt), 64'(pc));
    check("t6_state", 64'(dbg_state), 64'(ST_IDLE));
    check("t6_req_write", 64'(dram_req_write), 64'(0));

    // mismatched write-complete during a read is ignored
    dram_lat = 8;
    addr[2*AW +: AW] = 24'h000077;
    push_rd(4'b0100, 24'h000077, 32'hA5000077);
    req_read[2] = 1'b1;
    wait_for_req();
    inj_wc_req++;
    repeat (2) @(negedge clk);
    check("t7_write_complete", 64'(write_complete), 64'(0));
    check("t7_state", 64'(dbg_state), 64'(ST_BUSY_RD));
    wait_pulses(1);
    dram_lat = 3;

    // final report
    repeat (3) @(negedge clk);
    check("exp_q_empty", 64'(exp_q.size()), 64'(0));
    check("iss_q_empty", 64'(iss_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
